// File: rtl/pu_riscv_biu_arbiter_if.sv
// rtl/pu_riscv_biu_arbiter_if.sv - BIU request/response port bundle
interface pu_riscv_biu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  logic            stb;
  logic            stb_ack;
  logic            d_ack;
  logic [PLEN-1:0] adri;
  logic [2:0]      size;
  logic [2:0]      btype;
  logic [2:0]      prot;
  logic            lock;
  logic            we;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] q;
  logic [PLEN-1:0] adro;
  logic            ack;
  logic            err;

  // Requester side: issues requests, receives handshakes and read data
  modport master (
    output stb, adri, size, btype, prot, lock, we, d,
    input  stb_ack, d_ack, q, adro, ack, err
  );

  // Responder side: accepts requests, returns handshakes and read data
  modport slave (
    input  stb, adri, size, btype, prot, lock, we, d,
    output stb_ack, d_ack, q, adro, ack, err
  );
endinterface

// File: rtl/pu_riscv_biu_arbiter.sv
// rtl/pu_riscv_biu_arbiter.sv - round-robin two-master BIU arbiter
module pu_riscv_biu_arbiter (
  input logic                   HRESETn,
  input logic                   HCLK,
  pu_riscv_biu_arbiter_if.slave  ins_if,
  pu_riscv_biu_arbiter_if.slave  dat_if,
  pu_riscv_biu_arbiter_if.master biu_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INS  = 2'd1,
    DAT  = 2'd2
  } state_t;

  // last_q: 0 = instruction master, 1 = data master
  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [5:0] outs_q, outs_d;
  // served_q: current owner has had a request accepted during this tenure.
  // A fresh grantee must get one request through before it can be made to
  // yield, otherwise two masters requesting back to back would livelock.
  logic       served_q, served_d;

  logic       own_stb;
  logic       own_lock;
  logic [2:0] own_type;
  logic       oth_stb;
  logic       yield_w;
  logic       release_w;
  logic [5:0] sum_w;

  function automatic logic [5:0] beats(input logic [2:0] t);
    case (t)
      3'b000, 3'b001: beats = 6'd1;   // SINGLE, INCR
      3'b010, 3'b011: beats = 6'd4;   // WRAP4, INCR4
      3'b100, 3'b101: beats = 6'd8;   // WRAP8, INCR8
      3'b110, 3'b111: beats = 6'd16;  // WRAP16, INCR16
      default:        beats = 6'd1;
    endcase
  endfunction

  // Owner's view of its own request and the competing master's request
  always_comb begin
    own_stb  = 1'b0;
    own_lock = 1'b0;
    own_type = 3'b000;
    oth_stb  = 1'b0;
    case (state_q)
      INS: begin
        own_stb  = ins_if.stb;
        own_lock = ins_if.lock;
        own_type = ins_if.btype;
        oth_stb  = dat_if.stb;
      end
      DAT: begin
        own_stb  = dat_if.stb;
        own_lock = dat_if.lock;
        own_type = dat_if.btype;
        oth_stb  = ins_if.stb;
      end
      default: ;
    endcase
  end

  assign yield_w = oth_stb & ~own_lock & served_q;

  // Forward the owner's request fields downstream
  always_comb begin
    biu_if.stb   = (state_q != IDLE) & own_stb & ~yield_w;
    biu_if.adri  = ins_if.adri;
    biu_if.size  = ins_if.size;
    biu_if.btype = ins_if.btype;
    biu_if.prot  = ins_if.prot;
    biu_if.lock  = ins_if.lock;
    biu_if.we    = ins_if.we;
    biu_if.d     = ins_if.d;
    if (state_q == DAT) begin
      biu_if.adri  = dat_if.adri;
      biu_if.size  = dat_if.size;
      biu_if.btype = dat_if.btype;
      biu_if.prot  = dat_if.prot;
      biu_if.lock  = dat_if.lock;
      biu_if.we    = dat_if.we;
      biu_if.d     = dat_if.d;
    end
  end

  // Outstanding beat count: add on accept, subtract on ack, clear on error
  always_comb begin
    sum_w = outs_q;
    if (biu_if.stb_ack && state_q != IDLE) sum_w = outs_q + beats(own_type);
    if (biu_if.err)                        outs_d = 6'd0;
    else if (biu_if.ack && sum_w != 6'd0)  outs_d = sum_w - 6'd1;
    else                                   outs_d = sum_w;
  end

  assign release_w = (outs_d == 6'd0) & ~own_lock & (~own_stb | yield_w);

  // Ownership next-state, round-robin tie break and handoff
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    served_d = served_q;
    case (state_q)
      IDLE: begin
        served_d = 1'b0;
        if (ins_if.stb && dat_if.stb) begin
          if (last_q) begin
            state_d = INS;
            last_d  = 1'b0;
          end else begin
            state_d = DAT;
            last_d  = 1'b1;
          end
        end else if (ins_if.stb) begin
          state_d = INS;
          last_d  = 1'b0;
        end else if (dat_if.stb) begin
          state_d = DAT;
          last_d  = 1'b1;
        end
      end
      INS, DAT: begin
        if (biu_if.stb_ack) served_d = 1'b1;
        if (release_w) begin
          served_d = 1'b0;
          if (oth_stb) begin
            state_d = (state_q == INS) ? DAT : INS;
            last_d  = (state_q == INS);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      last_q   <= 1'b0;
      outs_q   <= 6'd0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      outs_q   <= outs_d;
      served_q <= served_d;
    end
  end

  // Handshakes go to the owner only; read data and address are broadcast
  assign ins_if.stb_ack = (state_q == INS) & biu_if.stb_ack;
  assign ins_if.d_ack   = (state_q == INS) & biu_if.d_ack;
  assign ins_if.ack     = (state_q == INS) & biu_if.ack;
  assign ins_if.err     = (state_q == INS) & biu_if.err;
  assign dat_if.stb_ack = (state_q == DAT) & biu_if.stb_ack;
  assign dat_if.d_ack   = (state_q == DAT) & biu_if.d_ack;
  assign dat_if.ack     = (state_q == DAT) & biu_if.ack;
  assign dat_if.err     = (state_q == DAT) & biu_if.err;
  assign ins_if.q       = biu_if.q;
  assign dat_if.q       = biu_if.q;
  assign ins_if.adro    = biu_if.adro;
  assign dat_if.adro    = biu_if.adro;

endmodule

// File: tb/tb_pu_riscv_biu_arbiter.sv
// tb/tb_pu_riscv_biu_arbiter.sv - directed vector bench for the BIU arbiter
module tb_pu_riscv_biu_arbiter;

  localparam logic [2:0] S  = 3'd0;
  localparam logic [2:0] W4 = 3'd2;
  localparam logic [2:0] I8 = 3'd5;
  localparam logic [63:0] INS_ADR = 64'h0000_0000_1000_0000;
  localparam logic [63:0] DAT_ADR = 64'h0000_0000_2000_0000;
  localparam logic [63:0] INS_D   = 64'h1111_1111_1111_1111;
  localparam logic [63:0] DAT_D   = 64'h2222_2222_2222_2222;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  pu_riscv_biu_arbiter_if #(.XLEN(64), .PLEN(64)) ins_bus ();
  pu_riscv_biu_arbiter_if #(.XLEN(64), .PLEN(64)) dat_bus ();
  pu_riscv_biu_arbiter_if #(.XLEN(64), .PLEN(64)) biu_bus ();

  pu_riscv_biu_arbiter dut (
    .HRESETn (HRESETn),
    .HCLK    (HCLK),
    .ins_if  (ins_bus),
    .dat_if  (dat_bus),
    .biu_if  (biu_bus)
  );

  // e = {biu_stb, ins_stb_ack, dat_stb_ack, ins_ack, dat_ack, ins_err, dat_err}
  typedef struct packed {
    logic       is_s;
    logic       il;
    logic [2:0] it;
    logic       ds;
    logic       dl;
    logic [2:0] dt;
    logic       sa;
    logic       ak;
    logic       er;
    logic [6:0] e;
    logic [5:0] eo;
    logic [1:0] es;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic is_s, input logic il, input logic [2:0] it,
                   input logic ds, input logic dl, input logic [2:0] dt,
                   input logic sa, input logic ak, input logic er,
                   input logic [6:0] e, input int eo, input int es);
    vec_t x;
    x.is_s = is_s; x.il = il; x.it = it;
    x.ds = ds; x.dl = dl; x.dt = dt;
    x.sa = sa; x.ak = ak; x.er = er;
    x.e = e; x.eo = 6'(eo); x.es = 2'(es);
    vq.push_back(x);
  endtask

  task automatic drive(input logic is_s, input logic il, input logic [2:0] it,
                       input logic ds, input logic dl, input logic [2:0] dt,
                       input logic sa, input logic ak, input logic er);
    ins_bus.stb = is_s; ins_bus.lock = il; ins_bus.btype = it;
    dat_bus.stb = ds;   dat_bus.lock = dl; dat_bus.btype = dt;
    biu_bus.stb_ack = sa; biu_bus.d_ack = sa;
    biu_bus.ack = ak;     biu_bus.err = er;
  endtask

  initial begin
    ins_bus.adri = INS_ADR; ins_bus.size = 3'd3; ins_bus.prot = 3'd4;
    ins_bus.we = 1'b0;      ins_bus.d = INS_D;
    dat_bus.adri = DAT_ADR; dat_bus.size = 3'd2; dat_bus.prot = 3'd1;
    dat_bus.we = 1'b1;      dat_bus.d = DAT_D;
    biu_bus.q = 64'h0;      biu_bus.adro = 64'h0;
    drive(0, 0, S, 0, 0, S, 0, 0, 0);

    // single ins read, back to idle
    v(0,0,S, 0,0,S,  0,0,0, 7'b0000000, 0, 0);
    v(1,0,S, 0,0,S,  0,0,0, 7'b0000000, 0, 0);
    v(1,0,S, 0,0,S,  1,0,0, 7'b1100000, 0, 1);
    v(0,0,S, 0,0,S,  0,1,0, 7'b0001000, 1, 1);
    v(0,0,S, 0,0,S,  0,0,0, 7'b0000000, 0, 0);
    // tie: dat first, then ins with no idle cycle
    v(1,0,S, 1,0,S,  0,0,0, 7'b0000000, 0, 0);
    v(1,0,S, 1,0,S,  1,0,0, 7'b1010000, 0, 2);
    v(1,0,S, 0,0,S,  0,1,0, 7'b0000100, 1, 2);
    v(1,0,S, 0,0,S,  1,0,0, 7'b1100000, 0, 1);
    v(0,0,S, 0,0,S,  0,1,0, 7'b0001000, 1, 1);
    v(0,0,S, 0,0,S,  0,0,0, 7'b0000000, 0, 0);
    // WRAP4 on dat with ins waiting
    v(0,0,S, 1,0,W4, 0,0,0, 7'b0000000, 0, 0);
    v(1,0,S, 1,0,W4, 1,0,0, 7'b1010000, 0, 2);
    v(1,0,S, 1,0,W4, 0,0,0, 7'b0000000, 4, 2);
    v(1,0,S, 1,0,W4, 0,1,0, 7'b0000100, 4, 2);
    v(1,0,S, 1,0,W4, 0,1,0, 7'b0000100, 3, 2);
    v(1,0,S, 1,0,W4, 0,1,0, 7'b0000100, 2, 2);
    v(1,0,S, 1,0,W4, 0,1,0, 7'b0000100, 1, 2);
    v(1,0,S, 1,0,W4, 0,0,0, 7'b1000000, 0, 1);
    v(1,0,S, 1,0,W4, 1,0,0, 7'b1100000, 0, 1);
    v(0,0,S, 0,0,S,  0,1,0, 7'b0001000, 1, 1);
    v(0,0,S, 0,0,S,  0,0,0, 7'b0000000, 0, 0);
    // locked dat pair holds off ins
    v(1,0,S, 1,1,S,  0,0,0, 7'b0000000, 0, 0);
    v(1,0,S, 1,1,S,  1,0,0, 7'b1010000, 0, 2);
    v(1,0,S, 0,1,S,  0,1,0, 7'b0000100, 1, 2);
    v(1,0,S, 1,1,S,  1,0,0, 7'b1010000, 0, 2);
    v(1,0,S, 0,0,S,  0,1,0, 7'b0000100, 1, 2);
    // INCR8 on ins, error after three acks, dat takes over
    v(1,0,I8, 0,0,S, 1,0,0, 7'b1100000, 0, 1);
    v(0,0,I8, 1,0,S, 0,1,0, 7'b0001000, 8, 1);
    v(0,0,I8, 1,0,S, 0,1,0, 7'b0001000, 7, 1);
    v(0,0,I8, 1,0,S, 0,1,0, 7'b0001000, 6, 1);
    v(0,0,I8, 1,0,S, 0,0,1, 7'b0000010, 5, 1);
    // stray ack with nothing outstanding saturates at zero
    v(0,0,S, 1,0,S,  0,1,0, 7'b1000100, 0, 2);
    v(0,0,S, 1,0,S,  0,0,0, 7'b1000000, 0, 2);
    v(0,0,S, 0,0,S,  0,0,0, 7'b0000000, 0, 2);
    v(0,0,S, 0,0,S,  0,0,0, 7'b0000000, 0, 0);

    // reset values while held in reset
    repeat (2) @(negedge HCLK);
    chk("rst.biu_stb", 64'(biu_bus.stb), 64'd0);
    chk("rst.outs", 64'(dut.outs_q), 64'd0);
    chk("rst.state", 64'(dut.state_q), 64'd0);
    HRESETn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      vec_t x;
      x = vq[i];
      @(negedge HCLK);
      drive(x.is_s, x.il, x.it, x.ds, x.dl, x.dt, x.sa, x.ak, x.er);
      biu_bus.q    = 64'hDEAD + 64'(i);
      biu_bus.adro = 64'hA000 + 64'(i);
      #1;
      chk($sformatf("r%0d.biu_stb", i),     64'(biu_bus.stb),     64'(x.e[6]));
      chk($sformatf("r%0d.ins_stb_ack", i), 64'(ins_bus.stb_ack), 64'(x.e[5]));
      chk($sformatf("r%0d.dat_stb_ack", i), 64'(dat_bus.stb_ack), 64'(x.e[4]));
      chk($sformatf("r%0d.ins_d_ack", i),   64'(ins_bus.d_ack),   64'(x.e[5]));
      chk($sformatf("r%0d.dat_d_ack", i),   64'(dat_bus.d_ack),   64'(x.e[4]));
      chk($sformatf("r%0d.ins_ack", i),     64'(ins_bus.ack),     64'(x.e[3]));
      chk($sformatf("r%0d.dat_ack", i),     64'(dat_bus.ack),     64'(x.e[2]));
      chk($sformatf("r%0d.ins_err", i),     64'(ins_bus.err),     64'(x.e[1]));
      chk($sformatf("r%0d.dat_err", i),     64'(dat_bus.err),     64'(x.e[0]));
      chk($sformatf("r%0d.outs", i),        64'(dut.outs_q),      64'(x.eo));
      chk($sformatf("r%0d.state", i),       64'(dut.state_q),     64'(x.es));
      chk($sformatf("r%0d.ins_q", i),       ins_bus.q,            64'hDEAD + 64'(i));
      chk($sformatf("r%0d.dat_adro", i),    dat_bus.adro,         64'hA000 + 64'(i));
      if (x.e[6]) begin
        chk($sformatf("r%0d.biu_adri", i), biu_bus.adri, (x.es == 2'd1) ? INS_ADR : DAT_ADR);
        chk($sformatf("r%0d.biu_d", i),    biu_bus.d,    (x.es == 2'd1) ? INS_D : DAT_D);
        chk($sformatf("r%0d.biu_type", i), 64'(biu_bus.btype), 64'((x.es == 2'd1) ? x.it : x.dt));
      end
    end

    // reset mid-burst: INCR8 accepted with a same-cycle ack, then two acks
    @(negedge HCLK); drive(1, 0, I8, 0, 0, S, 0, 0, 0);
    @(negedge HCLK); drive(1, 0, I8, 0, 0, S, 1, 1, 0);
    #1 chk("mb.ins_ack", 64'(ins_bus.ack), 64'd1);
    @(negedge HCLK); drive(1, 0, I8, 0, 0, S, 0, 1, 0);
    #1 chk("mb.outs_net", 64'(dut.outs_q), 64'd7);
    @(negedge HCLK); drive(1, 0, I8, 0, 0, S, 0, 1, 0);
    @(negedge HCLK); drive(1, 0, I8, 0, 0, S, 0, 0, 0);
    #1 chk("mb.outs5", 64'(dut.outs_q), 64'd5);
    chk("mb.biu_stb_pre", 64'(biu_bus.stb), 64'd1);
    drive(1, 0, I8, 0, 0, S, 1, 1, 0);
    HRESETn = 1'b0;
    #1;
    chk("mb.outs_rst", 64'(dut.outs_q), 64'd0);
    chk("mb.state_rst", 64'(dut.state_q), 64'd0);
    chk("mb.biu_stb_rst", 64'(biu_bus.stb), 64'd0);
    chk("mb.ins_stb_ack_rst", 64'(ins_bus.stb_ack), 64'd0);
    chk("mb.ins_ack_rst", 64'(ins_bus.ack), 64'd0);
    chk("mb.ins_d_ack_rst", 64'(ins_bus.d_ack), 64'd0);
    @(negedge HCLK); drive(0, 0, S, 0, 0, S, 0, 0, 0);
    HRESETn = 1'b1;
    // after reset the data master wins a tie again
    @(negedge HCLK); drive(1, 0, S, 1, 0, S, 0, 0, 0);
    @(negedge HCLK);
    #1 chk("post.state", 64'(dut.state_q), 64'd2);
    chk("post.biu_adri", biu_bus.adri, DAT_ADR);
    chk("post.biu_stb", 64'(biu_bus.stb), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
